// File: rtl/multicycle_control_unit.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer for the 10-bit ISA core.
// Optional macro MEM_TIMEOUT_EN bounds memory handshake waits to TIMEOUT_CYCLES.
module multicycle_control_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [3:0] OPCODE,
    input  logic       ZERO_FLAG,
    input  logic       IMEM_READY,
    input  logic       DMEM_READY,
    output logic       IMEM_REQ,
    output logic       DMEM_REQ,
    output logic       DMEM_WE,
    output logic       IR_LOAD,
    output logic       PC_INC,
    output logic       PC_LOAD,
    output logic       RF_WE,
    output logic [3:0] ALU_OP,
    output logic       ALU_SRC_IMM,
    output logic       WB_SEL,
    output logic       HALTED,
    output logic       ILLEGAL
);

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_SHL  = 4'b0110;
    localparam logic [3:0] OP_SHR  = 4'b0111;
    localparam logic [3:0] OP_LI   = 4'b1000;
    localparam logic [3:0] OP_LD   = 4'b1001;
    localparam logic [3:0] OP_ST   = 4'b1010;
    localparam logic [3:0] OP_JMP  = 4'b1011;
    localparam logic [3:0] OP_BEQZ = 4'b1100;
    localparam logic [3:0] OP_ADDI = 4'b1101;
    localparam logic [3:0] OP_ILL  = 4'b1110;
    localparam logic [3:0] OP_HALT = 4'b1111;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] op_q, op_d;
    logic       illegal_q, illegal_d;
    logic       tmo_hit;

    logic       imem_req, dmem_req, dmem_we, ir_load, pc_inc, pc_load;
    logic       rf_we, alu_src_imm, wb_sel, halted;
    logic [3:0] alu_op;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_FETCH;
            op_q      <= OP_NOP;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

    logic [TW-1:0] tmo_q, tmo_d;
    logic          mem_wait;

    assign mem_wait = ((state_q == S_FETCH) && !IMEM_READY) ||
                      ((state_q == S_MEMORY) && !DMEM_READY);
    // Fires on the wait cycle that would bring the count to TIMEOUT_CYCLES.
    assign tmo_hit  = mem_wait && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmo_d = '0;
        if (mem_wait && (state_d == state_q)) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    logic unused_timeout_cfg;

    assign tmo_hit            = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        illegal_d   = illegal_q;
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        ir_load     = 1'b0;
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        rf_we       = 1'b0;
        alu_op      = 4'b0000;
        alu_src_imm = 1'b0;
        wb_sel      = 1'b0;
        halted      = 1'b0;

        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (IMEM_READY) begin
                    ir_load = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = S_DECODE;
                end else if (tmo_hit) begin
                    state_d   = S_HALT;
                    illegal_d = 1'b1;
                end
            end

            S_DECODE: begin
                op_d = OPCODE;
                case (OPCODE)
                    OP_NOP:  state_d = S_FETCH;
                    OP_HALT: state_d = S_HALT;
                    OP_ILL: begin
                        state_d   = S_HALT;
                        illegal_d = 1'b1;
                    end
                    default: state_d = S_EXECUTE;
                endcase
            end

            S_EXECUTE: begin
                alu_op  = op_q;
                state_d = S_FETCH;
                case (op_q)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: begin
                        state_d = S_WRITEBACK;
                    end
                    // LI relies on the datapath masking R0 to zero so ADD yields imm.
                    OP_LI, OP_ADDI: begin
                        alu_op      = OP_ADD;
                        alu_src_imm = 1'b1;
                        state_d     = S_WRITEBACK;
                    end
                    OP_LD, OP_ST: state_d = S_MEMORY;
                    OP_JMP:       pc_load = 1'b1;
                    OP_BEQZ:      pc_load = ZERO_FLAG;
                    default:      state_d = S_FETCH;
                endcase
            end

            S_MEMORY: begin
                dmem_req = 1'b1;
                dmem_we  = (op_q == OP_ST);
                if (DMEM_READY) begin
                    state_d = (op_q == OP_LD) ? S_WRITEBACK : S_FETCH;
                end else if (tmo_hit) begin
                    state_d   = S_HALT;
                    illegal_d = 1'b1;
                end
            end

            S_WRITEBACK: begin
                rf_we   = 1'b1;
                wb_sel  = (op_q == OP_LD);
                state_d = S_FETCH;
            end

            S_HALT: begin
                halted = 1'b1;
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Gating with RST_N keeps every output low for the whole reset interval,
    // including IMEM_REQ, which FETCH would otherwise assert during reset.
    assign IMEM_REQ    = RST_N & imem_req;
    assign DMEM_REQ    = RST_N & dmem_req;
    assign DMEM_WE     = RST_N & dmem_we;
    assign IR_LOAD     = RST_N & ir_load;
    assign PC_INC      = RST_N & pc_inc;
    assign PC_LOAD     = RST_N & pc_load;
    assign RF_WE       = RST_N & rf_we;
    assign ALU_OP      = RST_N ? alu_op : 4'b0000;
    assign ALU_SRC_IMM = RST_N & alu_src_imm;
    assign WB_SEL      = RST_N & wb_sel;
    assign HALTED      = RST_N & halted;
    assign ILLEGAL     = RST_N & illegal_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit; all outputs packed into one vector per cycle.
module tb_multicycle_control_unit;

    logic       CLK;
    logic       RST_N;
    logic [3:0] OPCODE;
    logic       ZERO_FLAG;
    logic       IMEM_READY;
    logic       DMEM_READY;
    logic       IMEM_REQ, DMEM_REQ, DMEM_WE, IR_LOAD, PC_INC, PC_LOAD;
    logic       RF_WE, ALU_SRC_IMM, WB_SEL, HALTED, ILLEGAL;
    logic [3:0] ALU_OP;

    int errors = 0;
    int checks = 0;

    localparam logic [15:0] IMEM = 16'h0400;
    localparam logic [15:0] DREQ = 16'h0200;
    localparam logic [15:0] DWE  = 16'h0100;
    localparam logic [15:0] IRL  = 16'h0080;
    localparam logic [15:0] PCI  = 16'h0040;
    localparam logic [15:0] PCL  = 16'h0020;
    localparam logic [15:0] RFWE = 16'h0010;
    localparam logic [15:0] IMM  = 16'h0008;
    localparam logic [15:0] WBS  = 16'h0004;
    localparam logic [15:0] HLT  = 16'h0002;
    localparam logic [15:0] ILL  = 16'h0001;
    localparam logic [15:0] FET  = IMEM | IRL | PCI;

    logic [15:0] obs;
    assign obs = {1'b0, ALU_OP, IMEM_REQ, DMEM_REQ, DMEM_WE, IR_LOAD, PC_INC, PC_LOAD,
                  RF_WE, ALU_SRC_IMM, WB_SEL, HALTED, ILLEGAL};

    multicycle_control_unit #(.TIMEOUT_CYCLES(4)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .OPCODE     (OPCODE),
        .ZERO_FLAG  (ZERO_FLAG),
        .IMEM_READY (IMEM_READY),
        .DMEM_READY (DMEM_READY),
        .IMEM_REQ   (IMEM_REQ),
        .DMEM_REQ   (DMEM_REQ),
        .DMEM_WE    (DMEM_WE),
        .IR_LOAD    (IR_LOAD),
        .PC_INC     (PC_INC),
        .PC_LOAD    (PC_LOAD),
        .RF_WE      (RF_WE),
        .ALU_OP     (ALU_OP),
        .ALU_SRC_IMM(ALU_SRC_IMM),
        .WB_SEL     (WB_SEL),
        .HALTED     (HALTED),
        .ILLEGAL    (ILLEGAL)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [15:0] aop(input logic [3:0] o);
        return {1'b0, o, 11'b0};
    endfunction

    // Called at posedge+1 with inputs already set; checks mid-cycle, then moves on.
    task automatic cyc(input string tag, input logic [15:0] exp);
        #1;
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%04h expected=%04h", tag, obs, exp);
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST_N      = 1'b0;
        OPCODE     = 4'h0;
        ZERO_FLAG  = 1'b0;
        IMEM_READY = 1'b1;
        DMEM_READY = 1'b1;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        cyc("reset_all_zero", 16'h0000);
        RST_N = 1'b1;

        // ADD with ready tied high; opcode changed after DECODE to prove latching
        OPCODE = 4'h1;            cyc("add_fetch", FET);
        cyc("add_decode", 16'h0000);
        OPCODE = 4'hF;            cyc("add_execute", aop(4'h1));
        cyc("add_writeback", RFWE);

        // LD with DMEM_READY delayed 3 cycles
        OPCODE = 4'h9;            cyc("ld_fetch", FET);
        cyc("ld_decode", 16'h0000);
        DMEM_READY = 1'b0;        cyc("ld_execute", aop(4'h9));
        cyc("ld_mem_wait1", DREQ);
        cyc("ld_mem_wait2", DREQ);
        cyc("ld_mem_wait3", DREQ);
        DMEM_READY = 1'b1;        cyc("ld_mem_ready", DREQ);
        DMEM_READY = 1'b0;        cyc("ld_writeback", RFWE | WBS);

        // ST with one wait cycle
        OPCODE = 4'hA;            cyc("st_fetch", FET);
        cyc("st_decode", 16'h0000);
        cyc("st_execute", aop(4'hA));
        cyc("st_mem_wait", DREQ | DWE);
        DMEM_READY = 1'b1;        cyc("st_mem_ready", DREQ | DWE);

        // IMEM wait with stray DMEM_READY, then BEQZ taken
        IMEM_READY = 1'b0;        cyc("fetch_wait", IMEM);
        IMEM_READY = 1'b1; OPCODE = 4'hC; ZERO_FLAG = 1'b1;
        cyc("beqz1_fetch", FET);
        cyc("beqz1_decode", 16'h0000);
        cyc("beqz1_execute_taken", aop(4'hC) | PCL);

        // BEQZ not taken
        cyc("beqz0_fetch", FET);
        ZERO_FLAG = 1'b0;         cyc("beqz0_decode", 16'h0000);
        cyc("beqz0_execute_not_taken", aop(4'hC));

        // JMP
        OPCODE = 4'hB;            cyc("jmp_fetch", FET);
        cyc("jmp_decode", 16'h0000);
        cyc("jmp_execute", aop(4'hB) | PCL);

        // LI and ADDI use ADD with immediate operand
        OPCODE = 4'h8;            cyc("li_fetch", FET);
        cyc("li_decode", 16'h0000);
        cyc("li_execute", aop(4'h1) | IMM);
        cyc("li_writeback", RFWE);
        OPCODE = 4'hD;            cyc("addi_fetch", FET);
        cyc("addi_decode", 16'h0000);
        cyc("addi_execute", aop(4'h1) | IMM);
        cyc("addi_writeback", RFWE);

        // NOP takes two cycles, then SUB
        OPCODE = 4'h0;            cyc("nop_fetch", FET);
        cyc("nop_decode", 16'h0000);
        OPCODE = 4'h2;            cyc("sub_fetch", FET);
        cyc("sub_decode", 16'h0000);
        cyc("sub_execute", aop(4'h2));
        cyc("sub_writeback", RFWE);

        // Reset pulsed mid-MEMORY
        OPCODE = 4'h9;            cyc("rst_ld_fetch", FET);
        cyc("rst_ld_decode", 16'h0000);
        DMEM_READY = 1'b0;        cyc("rst_ld_execute", aop(4'h9));
        cyc("rst_ld_mem", DREQ);
        RST_N = 1'b0;             cyc("rst_mid_mem_drop", 16'h0000);
        RST_N = 1'b1; IMEM_READY = 1'b0;
        cyc("rst_restart_fetch", IMEM);

        // Illegal opcode halts with ILLEGAL, sticky and terminal
        IMEM_READY = 1'b1; DMEM_READY = 1'b1; OPCODE = 4'hE;
        cyc("ill_fetch", FET);
        cyc("ill_decode", 16'h0000);
        cyc("ill_halted", HLT | ILL);
        cyc("ill_halted_hold1", HLT | ILL);
        cyc("ill_halted_hold2", HLT | ILL);
        RST_N = 1'b0;             cyc("ill_reset_clears", 16'h0000);
        RST_N = 1'b1;

        // HALT opcode
        OPCODE = 4'hF;            cyc("halt_fetch", FET);
        cyc("halt_decode", 16'h0000);
        cyc("halt_halted", HLT);
        cyc("halt_halted_hold", HLT);

`ifdef MEM_TIMEOUT_EN
        RST_N = 1'b0;             cyc("tmo_reset", 16'h0000);
        RST_N = 1'b1; IMEM_READY = 1'b0;
        cyc("tmo_wait1", IMEM);
        cyc("tmo_wait2", IMEM);
        cyc("tmo_wait3", IMEM);
        cyc("tmo_wait4", IMEM);
        cyc("tmo_halted", HLT | ILL);
        IMEM_READY = 1'b1;        cyc("tmo_halted_hold", HLT | ILL);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
